sysid_checker: RTL and testbench
================================

# sysid_checker

Avalon-MM read master that sits directly upstream of the `sysid` slave. It drives the slave's 1-bit `address` and consumes its 32-bit `readdata`. After reset, or on request, it reads the system ID word (address 0) and the timestamp word (address 1), compares each against expected parameters, and reports the pass/fail result to the LCD control logic. This lets firmware and hardware refuse to run against a mismatched bitstream.

## Interface

Parameters:
- EXPECTED_ID, 12345678, value required at address 0.
- EXPECTED_TIMESTAMP, 1432136928, value required at address 1.
- READ_LATENCY, 0, number of extra cycles between presenting an address and sampling `readdata`. Range 0..7.
- AUTO_START, 1, if 1, one check launches automatically after reset.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  request a check; sampled only in IDLE or DONE.
- address  out  1  to sysid `address`.
- readdata  in  32  from sysid `readdata`.
- busy  out  1  check in progress.
- done  out  1  result valid.
- id_match  out  1  captured ID equals EXPECTED_ID.
- ts_match  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- pass  out  1  id_match & ts_match.
- captured_id  out  32  last word read at address 0.
- captured_ts  out  32  last word read at address 1.
- check_count  out  8  completed checks; saturates at 255.
- fail_count  out  8  completed checks with pass=0; saturates at 255.

## Operation

- States: IDLE, RD_ID, RD_TS, COMPARE, DONE.
- Reset (reset_n=0 at an edge): state=IDLE; pending=AUTO_START; all outputs 0; wait counter 0.
- IDLE or DONE: if start=1 or pending=1, go to RD_ID and clear pending, done, pass, id_match and ts_match. Otherwise hold.
- RD_ID: address=0 for READ_LATENCY+1 cycles. On the final cycle's edge, captured_id<=readdata and the state goes to RD_TS.
- RD_TS: address=1 for READ_LATENCY+1 cycles. On the final cycle's edge, captured_ts<=readdata and the state goes to COMPARE.
- COMPARE: one cycle. On its edge, the block registers:
  - id_match and ts_match, as full 32-bit equality;
  - pass;
  - check_count+1, saturating;
  - fail_count+1 if the check did not pass, saturating.
  It then goes to DONE.
- DONE: done=1. Results and captured words hold until the next start.
- busy=1 exactly in RD_ID, RD_TS and COMPARE.
- address=0 in every state except RD_TS.
- start while busy=1 is ignored, not queued.
- start held high in DONE relaunches every time DONE is re-entered. This is legal.
- Reset mid-check aborts immediately. There is no partial result. With AUTO_START=1, a fresh check runs after release.

## Timing

- Cycle n is the IDLE/DONE cycle where start (or pending) is sampled.
- RD_ID occupies cycles n+1 .. n+1+L, where L=READ_LATENCY.
- RD_TS occupies cycles n+2+L .. n+2+2L.
- COMPARE occupies cycle n+3+2L.
- done=1 from cycle n+4+2L. Start-to-done latency is 2L+4 cycles.
- With AUTO_START=1, L=0: cycle 0 is the first cycle with reset_n=1, and done rises in cycle 4.
- Outputs are registered. The exception is address, which decodes from the state register with no combinational path from inputs.
- readdata must be stable at the sampling edge. The block tolerates a combinational slave (L=0).

## Test plan

- Defaults, slave model returns 12345678 at address 0 and 1432136928 at address 1: release reset, then done=1 in cycle 4, pass=1, both matches 1, check_count=1, fail_count=0, busy=1 in cycles 1..3 only.
- Slave returns 0x00BC614F at address 0: pass=0, id_match=0, ts_match=1, captured_id=0x00BC614F, fail_count=1.
- READ_LATENCY=2, AUTO_START=0, start pulse in cycle 10: address=0 in cycles 11-13, address=1 in cycles 14-16, done in cycle 18. Slave data that changes before the sampling edge must not be captured.
- start pulsed at every cycle during busy: exactly one check completes, and check_count increments by 1.
- reset_n=0 during RD_TS, then released: all outputs are 0 the cycle after the reset edge, the check reruns, and the done timing matches the first scenario.
- start held high for 300 checks with a mismatching timestamp: check_count=255 and fail_count=255, with no wrap.

Source files
------------

// File: rtl/sysid_checker.sv
// Avalon-MM read master that reads the sysid slave's ID and timestamp words,
// compares them against the expected build values and reports the verdict.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd12345678,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1432136928,
    parameter int unsigned READ_LATENCY       = 0,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        pass,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts,
    output logic [7:0]  check_count,
    output logic [7:0]  fail_count
);

    typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, COMPARE, DONE} state_t;

    localparam logic [2:0] LAST_WAIT = 3'(READ_LATENCY);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [2:0]  wait_q, wait_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        id_match_q, id_match_d;
    logic        ts_match_q, ts_match_d;
    logic        pass_q, pass_d;
    logic [31:0] captured_id_q, captured_id_d;
    logic [31:0] captured_ts_q, captured_ts_d;
    logic [7:0]  check_count_q, check_count_d;
    logic [7:0]  fail_count_q, fail_count_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d       = state_q;
        pending_d     = pending_q;
        wait_d        = wait_q;
        id_match_d    = id_match_q;
        ts_match_d    = ts_match_q;
        pass_d        = pass_q;
        captured_id_d = captured_id_q;
        captured_ts_d = captured_ts_q;
        check_count_d = check_count_q;
        fail_count_d  = fail_count_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start || pending_q) begin
                    state_d    = RD_ID;
                    pending_d  = 1'b0;
                    wait_d     = 3'd0;
                    id_match_d = 1'b0;
                    ts_match_d = 1'b0;
                    pass_d     = 1'b0;
                end
            end
            RD_ID: begin
                if (wait_q == LAST_WAIT) begin
                    captured_id_d = readdata;
                    wait_d        = 3'd0;
                    state_d       = RD_TS;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            RD_TS: begin
                if (wait_q == LAST_WAIT) begin
                    captured_ts_d = readdata;
                    wait_d        = 3'd0;
                    state_d       = COMPARE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            COMPARE: begin
                id_match_d    = (captured_id_q == EXPECTED_ID);
                ts_match_d    = (captured_ts_q == EXPECTED_TIMESTAMP);
                pass_d        = id_match_d && ts_match_d;
                check_count_d = (check_count_q == 8'hFF) ? check_count_q : check_count_q + 8'd1;
                if (!pass_d && fail_count_q != 8'hFF) begin
                    fail_count_d = fail_count_q + 8'd1;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the next state so they are registered yet cycle-aligned.
        busy_d = (state_d == RD_ID) || (state_d == RD_TS) || (state_d == COMPARE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q       <= IDLE;
            pending_q     <= AUTO_START;
            wait_q        <= 3'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            id_match_q    <= 1'b0;
            ts_match_q    <= 1'b0;
            pass_q        <= 1'b0;
            captured_id_q <= 32'd0;
            captured_ts_q <= 32'd0;
            check_count_q <= 8'd0;
            fail_count_q  <= 8'd0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            wait_q        <= wait_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            id_match_q    <= id_match_d;
            ts_match_q    <= ts_match_d;
            pass_q        <= pass_d;
            captured_id_q <= captured_id_d;
            captured_ts_q <= captured_ts_d;
            check_count_q <= check_count_d;
            fail_count_q  <= fail_count_d;
        end
    end

    assign address     = (state_q == RD_TS);
    assign busy        = busy_q;
    assign done        = done_q;
    assign id_match    = id_match_q;
    assign ts_match    = ts_match_q;
    assign pass        = pass_q;
    assign captured_id = captured_id_q;
    assign captured_ts = captured_ts_q;
    assign check_count = check_count_q;
    assign fail_count  = fail_count_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: a default instance checked through a result
// scoreboard, plus a READ_LATENCY=2 manual-start instance checked cycle by cycle.
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID  = 32'd12345678;
    localparam logic [31:0] EXP_TS  = 32'd1432136928;
    localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

    typedef struct {
        logic        id_m;
        logic        ts_m;
        logic        pass;
        logic [31:0] cid;
        logic [31:0] cts;
        logic [7:0]  cc;
        logic [7:0]  fc;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Default instance
    logic        reset_n, start0, address0, busy0, done0, id_match0, ts_match0, pass0;
    logic [31:0] id_val0, ts_val0, rd0, captured_id0, captured_ts0;
    logic [7:0]  check_count0, fail_count0;

    assign rd0 = address0 ? ts_val0 : id_val0;

    sysid_checker dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start0),
        .address     (address0),
        .readdata    (rd0),
        .busy        (busy0),
        .done        (done0),
        .id_match    (id_match0),
        .ts_match    (ts_match0),
        .pass        (pass0),
        .captured_id (captured_id0),
        .captured_ts (captured_ts0),
        .check_count (check_count0),
        .fail_count  (fail_count0)
    );

    // Latency-2 instance with a slave whose data settles only on the last cycle
    logic        reset1_n, start1, address1, busy1, done1, id_match1, ts_match1, pass1;
    logic [31:0] rd1, captured_id1, captured_ts1;
    logic [7:0]  check_count1, fail_count1;

    sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0)) dut1 (
        .clock       (clock),
        .reset_n     (reset1_n),
        .start       (start1),
        .address     (address1),
        .readdata    (rd1),
        .busy        (busy1),
        .done        (done1),
        .id_match    (id_match1),
        .ts_match    (ts_match1),
        .pass        (pass1),
        .captured_id (captured_id1),
        .captured_ts (captured_ts1),
        .check_count (check_count1),
        .fail_count  (fail_count1)
    );

    int   ph1        = 0;
    logic prev_addr1 = 1'b0;
    logic prev_busy1 = 1'b0;

    always @(negedge clock) begin
        if (busy1 === 1'b1 && prev_busy1 === 1'b1 && address1 === prev_addr1) ph1++;
        else ph1 = 0;
        prev_addr1 = address1;
        prev_busy1 = busy1;
        rd1 = (ph1 >= 2) ? (address1 ? EXP_TS : EXP_ID) : GARBAGE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Scoreboard for the default instance
    exp_t       sb0[$];
    logic [7:0] m_cc = 8'd0;
    logic [7:0] m_fc = 8'd0;
    int         done_rises0 = 0;
    logic       done_prev0 = 1'b0;
    exp_t       got_e;

    task automatic push_exp(input logic [31:0] id, input logic [31:0] ts);
        exp_t e;
        e.id_m = (id == EXP_ID);
        e.ts_m = (ts == EXP_TS);
        e.pass = e.id_m && e.ts_m;
        e.cid  = id;
        e.cts  = ts;
        if (m_cc != 8'hFF) m_cc = m_cc + 8'd1;
        if (!e.pass && m_fc != 8'hFF) m_fc = m_fc + 8'd1;
        e.cc = m_cc;
        e.fc = m_fc;
        sb0.push_back(e);
    endtask

    always @(negedge clock) begin
        if (done0 === 1'b1 && done_prev0 !== 1'b1) begin
            done_rises0++;
            if (sb0.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                got_e = sb0.pop_front();
                check("id_match",    32'(id_match0),    32'(got_e.id_m));
                check("ts_match",    32'(ts_match0),    32'(got_e.ts_m));
                check("pass",        32'(pass0),        32'(got_e.pass));
                check("captured_id", captured_id0,      got_e.cid);
                check("captured_ts", captured_ts0,      got_e.cts);
                check("check_count", 32'(check_count0), 32'(got_e.cc));
                check("fail_count",  32'(fail_count0),  32'(got_e.fc));
            end
        end
        done_prev0 = done0;
    end

    task automatic wait_sb_empty(input int budget);
        int k = 0;
        while (sb0.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check("sb_drain_timeout", 32'(sb0.size()), 32'd0);
    endtask

    task automatic check_all_zero();
        check("rst_flags", {26'd0, busy0, done0, id_match0, ts_match0, pass0, address0}, 32'd0);
        check("rst_cap_id", captured_id0, 32'd0);
        check("rst_cap_ts", captured_ts0, 32'd0);
        check("rst_counts", {16'd0, check_count0, fail_count0}, 32'd0);
    endtask

    // Called in cycle 0, the first cycle with reset_n=1; ends in cycle 5.
    task automatic timing_after_release();
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            check($sformatf("busy_c%0d", c),    32'(busy0),    32'(c >= 1 && c <= 3));
            check($sformatf("done_c%0d", c),    32'(done0),    32'(c >= 4));
            check($sformatf("address_c%0d", c), 32'(address0), 32'(c == 2));
        end
    endtask

    initial begin
        int rises;
        int k;
        reset_n  = 1'b0;
        reset1_n = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        id_val0  = EXP_ID;
        ts_val0  = EXP_TS;

        // Reset, then the automatic check after release
        repeat (3) tick();
        check_all_zero();
        reset_n = 1'b1;
        push_exp(id_val0, ts_val0);
        timing_after_release();
        wait_sb_empty(5);

        // Mismatching ID word
        id_val0 = 32'h00BC_614F;
        push_exp(id_val0, ts_val0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_sb_empty(20);
        check("mm_cap_id", captured_id0, 32'h00BC_614F);
        check("mm_fail_count", 32'(fail_count0), 32'd1);

        // Start hammered while busy: one check only
        id_val0 = EXP_ID;
        rises = done_rises0;
        push_exp(id_val0, ts_val0);
        start0 = 1'b1;
        tick();
        repeat (12) begin
            start0 = busy0;
            tick();
        end
        start0 = 1'b0;
        check("spam_done_rises", 32'(done_rises0 - rises), 32'd1);
        check("spam_sb_empty", 32'(sb0.size()), 32'd0);
        check("spam_check_count", 32'(check_count0), 32'd3);

        // Reset during RD_TS aborts; auto check reruns
        push_exp(id_val0, ts_val0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0;
        while (address0 !== 1'b1 && k < 6) begin
            tick();
            k++;
        end
        check("reach_rd_ts", 32'(address0), 32'd1);
        reset_n = 1'b0;
        sb0.delete();
        m_cc = 8'd0;
        m_fc = 8'd0;
        tick();
        check_all_zero();
        reset_n = 1'b1;
        push_exp(id_val0, ts_val0);
        timing_after_release();
        wait_sb_empty(5);

        // 300 back-to-back failing checks: counters saturate
        ts_val0 = EXP_TS ^ 32'd1;
        for (int i = 0; i < 300; i++) push_exp(id_val0, ts_val0);
        start0 = 1'b1;
        k = 0;
        while (!(sb0.size() <= 1 && busy0 === 1'b1) && k < 2000) begin
            tick();
            k++;
        end
        start0 = 1'b0;
        wait_sb_empty(20);
        check("sat_check_count", 32'(check_count0), 32'd255);
        check("sat_fail_count",  32'(fail_count0),  32'd255);

        // Latency-2 instance, start pulse in cycle 10
        repeat (2) tick();
        reset1_n = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            check($sformatf("l2_busy_c%0d", c), 32'(busy1), 32'(c >= 11 && c <= 17));
            check($sformatf("l2_done_c%0d", c), 32'(done1), 32'(c >= 18));
            if (c >= 11)
                check($sformatf("l2_address_c%0d", c), 32'(address1), 32'(c >= 14 && c <= 16));
            start1 = (c == 10);
        end
        check("l2_pass",        32'(pass1),        32'd1);
        check("l2_captured_id", captured_id1,      EXP_ID);
        check("l2_captured_ts", captured_ts1,      EXP_TS);
        check("l2_check_count", 32'(check_count1), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
